// File: rtl/branch_resolve_if.sv
// ID/EX -> EX -> MEM bundle for the branch resolution stage.
// The slave side is the resolver; the master side is whatever drives the
// instruction in and consumes the resolved result.
interface branch_resolve_if;
  // Instruction side (ID/EX)
  logic        valid_i;
  logic        ready_o;
  logic        is_branch_i;
  logic        is_jal_i;
  logic        is_jalr_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;

  // Result side (MEM) plus fetch redirect and status
  logic        valid_o;
  logic        ready_i;
  logic        taken_o;
  logic [31:0] link_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        excp_o;
  logic        squash_o;
  logic [31:0] br_cnt_o;
  logic [31:0] taken_cnt_o;

  modport slave (
    input  valid_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i,
           pc_i, imm_i, rs1_data_i, rs2_data_i, ready_i,
    output ready_o, valid_o, taken_o, link_o, redirect_o, redirect_pc_o,
           excp_o, squash_o, br_cnt_o, taken_cnt_o
  );

  modport master (
    output valid_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i,
           pc_i, imm_i, rs1_data_i, rs2_data_i, ready_i,
    input  ready_o, valid_o, taken_o, link_o, redirect_o, redirect_pc_o,
           excp_o, squash_o, br_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution for the RV32I core.
// Evaluates the branch condition from the magnitude comparator, computes the
// target, pulses a one-cycle fetch redirect, drops KILL_CNT younger wrong-path
// instructions and hands the result to MEM through a registered valid/ready
// stage. Also keeps wrapping counts of resolved and taken transfers.

// Magnitude comparator shared with the rest of the core.
module mag_compare #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         signed_i,
  output logic         less_o,
  output logic         equal_o
);
  assign less_o  = signed_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
  assign equal_o = (a_i == b_i);
endmodule

module branch_resolve #(
  parameter int KILL_CNT = 2,   // younger accepted instructions dropped after a redirect (0..7)
  parameter int XLEN     = 32   // only 32 is supported
) (
  input  logic            clk_i,
  input  logic            rst_i,
  branch_resolve_if.slave bus
);

  localparam logic [2:0] KILL_LD = 3'(KILL_CNT);

  // Handshake and squash control
  logic            accept;
  logic            squash;
  logic            load;
  logic [2:0]      sq_cnt;

  // Condition / target evaluation
  logic            less;
  logic            equal;
  logic            cond;
  logic            bad_f3;
  logic            is_ctrl;
  logic            raw_taken;
  logic            misalign;
  logic            taken_nx;
  logic            excp_nx;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  // Registered outputs
  logic            valid_q;
  logic            taken_q;
  logic            excp_q;
  logic [XLEN-1:0] link_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [XLEN-1:0] br_cnt_q;
  logic [XLEN-1:0] taken_cnt_q;

  // funct3[1] = 1 selects the unsigned compares (LTU/GEU).
  mag_compare #(.W(XLEN)) u_cmp (
    .a_i      (bus.rs1_data_i),
    .b_i      (bus.rs2_data_i),
    .signed_i (~bus.funct3_i[1]),
    .less_o   (less),
    .equal_o  (equal)
  );

  assign bus.ready_o = ~valid_q | bus.ready_i;
  assign accept      = bus.valid_i & bus.ready_o;
  assign squash      = accept & (sq_cnt != 3'd0);
  assign load        = accept & ~squash;
  assign bus.squash_o = squash;

  // Decode the branch condition; 010/011 have no branch meaning.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    cond   = 1'b0;
    bad_f3 = 1'b0;
    case (bus.funct3_i)
      3'b000:         cond = equal;
      3'b001:         cond = ~equal;
      3'b100, 3'b110: cond = less;
      3'b101, 3'b111: cond = ~less;
      default:        bad_f3 = 1'b1;
    endcase
  end

  // JALR targets drop bit 0; everything else is PC-relative. Sums wrap.
  assign pc_sum   = bus.pc_i + bus.imm_i;
  assign jalr_sum = bus.rs1_data_i + bus.imm_i;
  assign target   = bus.is_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : pc_sum;

  assign is_ctrl   = bus.is_branch_i | bus.is_jal_i | bus.is_jalr_i;
  assign raw_taken = bus.is_jal_i | bus.is_jalr_i
                   | (bus.is_branch_i & cond & ~bad_f3);
  // A taken transfer to a non-word-aligned target becomes an exception instead.
  assign misalign  = raw_taken & target[1];
  assign taken_nx  = raw_taken & ~misalign;
  assign excp_nx   = (bus.is_branch_i & bad_f3) | misalign;

  // Output register: load on a kept accept, empty on drain, hold while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      excp_q  <= 1'b0;
      link_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      taken_q <= taken_nx;
      excp_q  <= excp_nx;
      link_q  <= bus.pc_i + 32'd4;
    end else if (bus.ready_o) begin
      valid_q <= 1'b0;
    end
  end

  // Redirect pulse lines up with valid_o rising; the target is held between pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= load & taken_nx;
      if (load & taken_nx) redirect_pc_q <= target;
    end
  end

  // Wrong-path kill counter: armed by a redirect, counts down per dropped beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_cnt <= 3'd0;
    end else if (load & taken_nx) begin
      sq_cnt <= KILL_LD;
    end else if (squash) begin
      sq_cnt <= sq_cnt - 3'd1;
    end
  end

  // Performance counters advance on the same edge the output register loads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (load & is_ctrl) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (taken_nx) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign bus.valid_o       = valid_q;
  assign bus.taken_o       = taken_q;
  assign bus.excp_o        = excp_q;
  assign bus.link_o        = link_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.br_cnt_o      = br_cnt_q;
  assign bus.taken_cnt_o   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: a vector table swept in a loop,
// a scoreboard of expected MEM results popped when the DUT hands one over,
// and hand-written sequences for squash, back-pressure and mid-run reset.
module tb_branch_resolve;

  localparam int KILL = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  branch_resolve_if bus ();

  branch_resolve #(.KILL_CNT(KILL), .XLEN(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        br;
    logic        jal;
    logic        jalr;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        taken;
    logic        excp;
    logic [31:0] target;
  } vec_t;

  typedef struct {
    logic        taken;
    logic        excp;
    logic [31:0] link;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        tbl[14];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_br   = '0;
  logic [31:0] exp_tk   = '0;
  logic [31:0] last_tgt = '0;

  function automatic logic [31:0] b32(input logic b);
    return {31'b0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic br, input logic jal, input logic jalr,
                              input logic [2:0] f3, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic taken,
                              input logic excp, input logic [31:0] target);
    vec_t v;
    v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3; v.pc = pc; v.imm = imm;
    v.rs1 = rs1; v.rs2 = rs2; v.taken = taken; v.excp = excp; v.target = target;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.is_branch_i = v.br;
    bus.is_jal_i    = v.jal;
    bus.is_jalr_i   = v.jalr;
    bus.funct3_i    = v.f3;
    bus.pc_i        = v.pc;
    bus.imm_i       = v.imm;
    bus.rs1_data_i  = v.rs1;
    bus.rs2_data_i  = v.rs2;
  endtask

  // Record what MEM should see for a kept instruction, and the counter deltas.
  task automatic expect_result(input vec_t v);
    sb.push_back('{taken: v.taken, excp: v.excp, link: v.pc + 32'd4});
    if (v.br | v.jal | v.jalr) begin
      exp_br++;
      if (v.taken) exp_tk++;
    end
  endtask

  // Present one instruction, wait for acceptance, then check squash and redirect.
  task automatic send(input vec_t v, input logic exp_sq);
    int waited = 0;
    drive(v);
    bus.valid_i = 1'b1;
    #1;
    while (!bus.ready_o && waited < 20) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (!bus.ready_o) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles", waited);
      bus.valid_i = 1'b0;
      return;
    end
    check("squash_o", b32(bus.squash_o), b32(exp_sq));
    if (!exp_sq) expect_result(v);
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    check("redirect_o", b32(bus.redirect_o), b32(!exp_sq && v.taken));
    if (!exp_sq && v.taken) last_tgt = v.target;
    check("redirect_pc_o", bus.redirect_pc_o, last_tgt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid_o"},     b32(bus.valid_o),    32'd0);
    check({tag, "_taken_o"},     b32(bus.taken_o),    32'd0);
    check({tag, "_excp_o"},      b32(bus.excp_o),     32'd0);
    check({tag, "_redirect_o"},  b32(bus.redirect_o), 32'd0);
    check({tag, "_squash_o"},    b32(bus.squash_o),   32'd0);
    check({tag, "_link_o"},      bus.link_o,          32'd0);
    check({tag, "_redir_pc_o"},  bus.redirect_pc_o,   32'd0);
    check({tag, "_br_cnt_o"},    bus.br_cnt_o,        32'd0);
    check({tag, "_taken_cnt_o"}, bus.taken_cnt_o,     32'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_br_cnt_o"},    bus.br_cnt_o,    exp_br);
    check({tag, "_taken_cnt_o"}, bus.taken_cnt_o, exp_tk);
  endtask

  // Scoreboard: a result is consumed at the edge following a negedge with valid&ready.
  always @(negedge clk_i) begin
    if (!rst_i && bus.valid_o && bus.ready_i) begin
      if (sb.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_unexpected: valid_o=1 with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check("sb_taken_o", b32(bus.taken_o), b32(mon_e.taken));
        check("sb_excp_o",  b32(bus.excp_o),  b32(mon_e.excp));
        check("sb_link_o",  bus.link_o,       mon_e.link);
      end
    end
  end

  // Asynchronous reset in the middle of a pending squash window.
  task automatic mid_reset(input vec_t redir, input vec_t filler, input int pre_squash);
    send(redir, 1'b0);
    for (int k = 0; k < pre_squash; k++) send(filler, 1'b1);
    drive(filler);
    bus.valid_i = 1'b1;
    #1;
    check("pre_reset_squash_o", b32(bus.squash_o), 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    sb.delete();
    exp_br   = '0;
    exp_tk   = '0;
    last_tgt = '0;
    check_zero("midrst");
    bus.valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    send(filler, 1'b0);
    check_counts("post_rst");
  endtask

  vec_t nop, beq_t, bne_n, beq_n, bad010;
  logic [31:0] snap_link;
  logic [31:0] snap_br;
  logic [31:0] snap_tk;
  logic        snap_taken;

  initial begin
    // Vector table: {is_branch, is_jal, is_jalr, funct3, pc, imm, rs1, rs2, taken, excp, target}
    tbl[0]  = mk(1,0,0,3'b100,32'h100,32'h20,32'hFFFFFFFF,32'h1,1,0,32'h120);      // BLT signed
    tbl[1]  = mk(1,0,0,3'b110,32'h100,32'h20,32'hFFFFFFFF,32'h1,0,0,32'h120);      // BLTU
    tbl[2]  = mk(0,0,1,3'b000,32'h200,32'h0,32'h1003,32'h0,0,1,32'h1002);          // JALR misaligned
    tbl[3]  = mk(0,0,1,3'b000,32'h204,32'h0,32'h1001,32'h0,1,0,32'h1000);          // JALR bit0 cleared
    tbl[4]  = mk(1,0,0,3'b000,32'h300,32'hFFFFFFF0,32'h5,32'h5,1,0,32'h2F0);       // BEQ backward
    tbl[5]  = mk(1,0,0,3'b001,32'h304,32'h40,32'h5,32'h5,0,0,32'h344);             // BNE equal
    tbl[6]  = mk(1,0,0,3'b101,32'h308,32'h8,32'hFFFFFFFF,32'h1,0,0,32'h310);       // BGE -1>=1
    tbl[7]  = mk(1,0,0,3'b111,32'h400,32'h8,32'hFFFFFFFF,32'h1,1,0,32'h408);       // BGEU
    tbl[8]  = mk(1,0,0,3'b010,32'h500,32'h8,32'h5,32'h5,0,1,32'h508);              // illegal 010
    tbl[9]  = mk(1,0,0,3'b011,32'h504,32'h8,32'h5,32'h6,0,1,32'h50C);              // illegal 011
    tbl[10] = mk(0,1,0,3'b000,32'hFFFFFFFC,32'h8,32'h0,32'h0,1,0,32'h4);           // JAL wraps
    tbl[11] = mk(0,0,0,3'b000,32'h600,32'h10,32'h1,32'h2,0,0,32'h610);             // non-control
    tbl[12] = mk(1,0,0,3'b100,32'h100,32'h2,32'h1,32'h2,0,1,32'h102);              // BLT misaligned
    tbl[13] = mk(1,0,0,3'b001,32'h100,32'h2,32'h5,32'h5,0,0,32'h102);              // BNE not taken, odd target

    nop    = mk(0,0,0,3'b000,32'h700,32'h0,32'h0,32'h0,0,0,32'h700);
    beq_t  = mk(1,0,0,3'b000,32'h800,32'h100,32'h7,32'h7,1,0,32'h900);
    bne_n  = mk(1,0,0,3'b001,32'h804,32'h100,32'h7,32'h7,0,0,32'h904);
    beq_n  = mk(1,0,0,3'b000,32'h808,32'h100,32'h7,32'h8,0,0,32'h908);
    bad010 = mk(1,0,0,3'b010,32'h80C,32'h100,32'h7,32'h7,0,1,32'h90C);

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    drive(nop);

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset");
    check("reset_ready_o", b32(bus.ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Table sweep; each taken entry is followed by the beats it kills.
    for (int i = 0; i < 14; i++) begin
      send(tbl[i], 1'b0);
      if (tbl[i].taken) begin
        for (int k = 0; k < KILL; k++) send(nop, 1'b1);
      end
    end
    check_counts("table");

    // Taken BEQ then three back-to-back controls: two dropped, third kept.
    send(beq_t, 1'b0);
    send(bne_n, 1'b1);
    send(bne_n, 1'b1);
    send(bne_n, 1'b0);
    check("kill_valid_o", b32(bus.valid_o), 32'd1);
    check("kill_link_o",  bus.link_o, bne_n.pc + 32'd4);
    check_counts("kill");

    // Illegal funct3 counts as resolved but never taken.
    snap_br = bus.br_cnt_o;
    snap_tk = bus.taken_cnt_o;
    send(bad010, 1'b0);
    check("f3_010_excp_o", b32(bus.excp_o), 32'd1);
    check("f3_010_br_cnt", bus.br_cnt_o, snap_br + 32'd1);
    check("f3_010_tk_cnt", bus.taken_cnt_o, snap_tk);

    // Back-pressure: hold ready_i low for 4 cycles with a result waiting.
    @(posedge clk_i); #1;
    bus.ready_i = 1'b0;
    send(bne_n, 1'b0);
    snap_link  = bus.link_o;
    snap_taken = bus.taken_o;
    snap_br    = bus.br_cnt_o;
    snap_tk    = bus.taken_cnt_o;
    drive(beq_n);
    bus.valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("stall_ready_o",  b32(bus.ready_o),  32'd0);
      check("stall_valid_o",  b32(bus.valid_o),  32'd1);
      check("stall_squash_o", b32(bus.squash_o), 32'd0);
      check("stall_link_o",   bus.link_o,        snap_link);
      check("stall_taken_o",  b32(bus.taken_o),  b32(snap_taken));
      check("stall_br_cnt",   bus.br_cnt_o,      snap_br);
      check("stall_tk_cnt",   bus.taken_cnt_o,   snap_tk);
      @(posedge clk_i); #1;
    end
    bus.ready_i = 1'b1;
    #1;
    check("release_ready_o", b32(bus.ready_o), 32'd1);
    expect_result(beq_n);
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    check("release_link_o", bus.link_o, beq_n.pc + 32'd4);
    check_counts("release");

    // Mid-run reset: once with count 1 pending, once right after the redirect.
    @(posedge clk_i); #1;
    mid_reset(beq_t, bne_n, 1);
    @(posedge clk_i); #1;
    mid_reset(beq_t, bne_n, 0);

    // Let the scoreboard drain.
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk_i);
    @(posedge clk_i); #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
